// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, and presents one registered instruction to the decoder.
// Latency: instValid rises on the edge that samples imemValid; sustains one instruction per cycle with zero-wait memory.
// Backpressure: a one-entry prefetch buffer absorbs one word while decodeReady=0, after which the request is dropped.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   input  logic        decodeReady,
   output logic        instValid,
   output logic [31:0] instruction,
   output logic [31:0] instPC,
   output logic [31:0] instPCPlus4,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   output logic        misalignFault
);

   // IDLE: request off, waiting for the first edge after reset.
   // WAIT: request on, output register empty.
   // HOLD: output register valid, request on for the next PC.
   // FULL: output register and prefetch buffer both valid, request off.
   // HALT: misaligned redirect seen; only reset leaves this state.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      HOLD = 3'd2,
      FULL = 3'd3,
      HALT = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buf_inst;
   logic [31:0] buf_pc;

   logic        redir_live;
   logic        redir_bad;

   // The request address is the PC itself, so it only moves when the PC register does.
   assign imemAddr = pc;

   // Link value for jal/jalr; wraps modulo 2^32 like the PC.
   assign instPCPlus4 = instPC + 32'd4;

   // Redirects only matter while fetching; IDLE and HALT ignore them.
   assign redir_live = redirect && ((state == WAIT) || (state == HOLD) || (state == FULL));
   assign redir_bad  = redir_live && (redirectTarget[1:0] != 2'b00);

   // Fetch FSM with registered outputs: PC, output register, prefetch buffer and fault flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         imemReq       <= 1'b0;
         instValid     <= 1'b0;
         instruction   <= NOP_INST;
         instPC        <= 32'd0;
         buf_inst      <= NOP_INST;
         buf_pc        <= 32'd0;
         misalignFault <= 1'b0;
      end else if (redir_bad) begin
         // A misaligned target is a fatal fetch error: stop fetching, keep the PC where it was.
         state         <= HALT;
         misalignFault <= 1'b1;
         imemReq       <= 1'b0;
         instValid     <= 1'b0;
         instruction   <= NOP_INST;
      end else if (redir_live) begin
         // Flush everything in flight, including any word returned this cycle and the buffer.
         state       <= WAIT;
         pc          <= redirectTarget;
         imemReq     <= 1'b1;
         instValid   <= 1'b0;
         instruction <= NOP_INST;
      end else begin
         case (state)
            IDLE: begin
               state   <= WAIT;
               imemReq <= 1'b1;
            end

            WAIT: begin
               // Output is empty, so decodeReady has nothing to consume here.
               if (imemValid) begin
                  state       <= HOLD;
                  instValid   <= 1'b1;
                  instruction <= imemData;
                  instPC      <= pc;
                  pc          <= pc + 32'd4;
               end
            end

            HOLD: begin
               if (decodeReady && imemValid) begin
                  // Streaming case: consume and refill in the same cycle.
                  instruction <= imemData;
                  instPC      <= pc;
                  pc          <= pc + 32'd4;
               end else if (decodeReady) begin
                  state       <= WAIT;
                  instValid   <= 1'b0;
                  instruction <= NOP_INST;
               end else if (imemValid) begin
                  // Decoder stalled: park the new word and stop requesting.
                  state    <= FULL;
                  buf_inst <= imemData;
                  buf_pc   <= pc;
                  pc       <= pc + 32'd4;
                  imemReq  <= 1'b0;
               end
            end

            FULL: begin
               // Request is low here, so imemValid carries nothing for us.
               if (decodeReady) begin
                  state       <= HOLD;
                  instruction <= buf_inst;
                  instPC      <= buf_pc;
                  imemReq     <= 1'b1;
               end
            end

            HALT: begin
               imemReq   <= 1'b0;
               instValid <= 1'b0;
            end

            default: begin
               state     <= HALT;
               imemReq   <= 1'b0;
               instValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a directed cycle table followed by randomized traffic checked against a queue model.
// The model treats the output register plus prefetch buffer as a two-entry FIFO fed by an in-order PC stream.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemData;
   logic        decodeReady;
   logic        instValid;
   logic [31:0] instruction;
   logic [31:0] instPC;
   logic [31:0] instPCPlus4;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic        misalignFault;

   int checks   = 0;
   int failures = 0;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imemReq       (imemReq),
      .imemAddr      (imemAddr),
      .imemValid     (imemValid),
      .imemData      (imemData),
      .decodeReady   (decodeReady),
      .instValid     (instValid),
      .instruction   (instruction),
      .instPC        (instPC),
      .instPCPlus4   (instPCPlus4),
      .redirect      (redirect),
      .redirectTarget(redirectTarget),
      .misalignFault (misalignFault)
   );

   always #5 clk = ~clk;

   // Memory contents: word at address 0 is 0x00500093, others derived from the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h0050_0093;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        vld;
      logic        rdy;
      logic        rdr;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ivld;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
      logic        e_flt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic vld, input logic rdy, input logic rdr, input logic [31:0] tgt,
                      input logic e_req, input logic [31:0] e_addr, input logic e_ivld, input logic [31:0] e_ipc,
                      input logic e_flt);
      vec_t v;
      v.rst = rst; v.vld = vld; v.rdy = rdy; v.rdr = rdr; v.tgt = tgt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_ivld = e_ivld;
      v.e_inst = e_ivld ? mem(e_ipc) : NOP;
      v.e_ipc = e_ipc; v.e_flt = e_flt;
      tbl.push_back(v);
   endtask

   // Reference model state
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_started;
   bit          m_halt;
   bit          m_flt;

   task automatic model_reset();
      mq.delete();
      m_pc      = 32'h0;
      m_started = 0;
      m_halt    = 0;
      m_flt     = 0;
   endtask

   task automatic model_step(input logic rst, input logic vld, input logic rdy, input logic rdr,
                             input logic [31:0] tgt);
      bit req;
      if (rst) begin
         model_reset();
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_halt) begin
         // only reset leaves the halt
      end else if (rdr) begin
         mq.delete();
         if (tgt[1:0] != 2'b00) begin
            m_halt = 1;
            m_flt  = 1;
         end else begin
            m_pc = tgt;
         end
      end else begin
         req = (mq.size() < 2);
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (req && vld) begin
            mq.push_back({mem(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic model_compare(input int cyc);
      logic        e_req;
      logic        e_ivld;
      e_req  = m_started && !m_halt && (mq.size() < 2);
      e_ivld = (mq.size() > 0);
      chk($sformatf("rnd%0d imemReq", cyc), {31'd0, imemReq}, {31'd0, e_req});
      chk($sformatf("rnd%0d imemAddr", cyc), imemAddr, m_pc);
      chk($sformatf("rnd%0d instValid", cyc), {31'd0, instValid}, {31'd0, e_ivld});
      chk($sformatf("rnd%0d misalignFault", cyc), {31'd0, misalignFault}, {31'd0, m_flt});
      if (e_ivld) begin
         chk($sformatf("rnd%0d instruction", cyc), instruction, mq[0].inst);
         chk($sformatf("rnd%0d instPC", cyc), instPC, mq[0].pc);
         chk($sformatf("rnd%0d instPCPlus4", cyc), instPCPlus4, mq[0].pc + 32'd4);
      end else begin
         chk($sformatf("rnd%0d instruction_nop", cyc), instruction, NOP);
      end
   endtask

   initial begin
      reset = 1'b1; imemValid = 1'b0; imemData = 32'h0; decodeReady = 1'b0;
      redirect = 1'b0; redirectTarget = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst imemReq", {31'd0, imemReq}, 32'd0);
      chk("rst imemAddr", imemAddr, 32'h0);
      chk("rst instValid", {31'd0, instValid}, 32'd0);
      chk("rst instruction", instruction, NOP);
      chk("rst instPC", instPC, 32'h0);
      chk("rst instPCPlus4", instPCPlus4, 32'h4);
      chk("rst misalignFault", {31'd0, misalignFault}, 32'd0);

      // rst vld rdy rdr tgt | req addr ivld ipc flt
      add(0, 0, 1, 0, 0,            1, 32'h0,   0, 0,            0); // IDLE -> WAIT
      add(0, 1, 1, 0, 0,            1, 32'h4,   1, 32'h0,        0); // first word
      add(0, 1, 1, 0, 0,            1, 32'h8,   1, 32'h4,        0); // streaming
      add(0, 1, 1, 0, 0,            1, 32'hC,   1, 32'h8,        0);
      add(0, 0, 1, 0, 0,            1, 32'hC,   0, 0,            0); // bubble -> WAIT
      add(0, 1, 0, 0, 0,            1, 32'h10,  1, 32'hC,        0); // WAIT -> HOLD
      add(0, 1, 0, 0, 0,            0, 32'h14,  1, 32'hC,        0); // stall -> FULL
      add(0, 1, 0, 0, 0,            0, 32'h14,  1, 32'hC,        0); // FULL ignores imemValid
      add(0, 0, 1, 0, 0,            1, 32'h14,  1, 32'h10,       0); // buffer drains
      add(0, 1, 0, 0, 0,            0, 32'h18,  1, 32'h10,       0); // FULL again
      add(0, 1, 1, 1, 32'h100,      1, 32'h100, 0, 0,            0); // redirect from FULL
      add(0, 1, 1, 0, 0,            1, 32'h104, 1, 32'h100,      0); // buffered word gone
      add(0, 0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0,       0); // redirect to top word
      add(0, 1, 1, 0, 0,            1, 32'h0,   1, 32'hFFFFFFFC, 0); // PC wraps
      add(0, 1, 1, 0, 0,            1, 32'h4,   1, 32'h0,        0);
      add(0, 1, 1, 1, 32'h102,      0, 32'h4,   0, 0,            1); // misaligned -> HALT
      add(0, 1, 1, 1, 32'h200,      0, 32'h4,   0, 0,            1); // redirect ignored in HALT
      add(0, 1, 1, 0, 0,            0, 32'h4,   0, 0,            1);
      add(1, 1, 1, 0, 0,            0, 32'h0,   0, 0,            0); // reset clears fault
      add(0, 0, 1, 0, 0,            1, 32'h0,   0, 0,            0);
      add(0, 1, 1, 0, 0,            1, 32'h4,   1, 32'h0,        0);
      add(1, 1, 1, 0, 0,            0, 32'h0,   0, 0,            0); // reset mid-stream
      add(0, 0, 0, 0, 0,            1, 32'h0,   0, 0,            0);

      for (int i = 0; i < tbl.size(); i++) begin
         reset          = tbl[i].rst;
         imemValid      = tbl[i].vld;
         decodeReady    = tbl[i].rdy;
         redirect       = tbl[i].rdr;
         redirectTarget = tbl[i].tgt;
         imemData       = mem(imemAddr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d imemReq", i), {31'd0, imemReq}, {31'd0, tbl[i].e_req});
         chk($sformatf("v%0d imemAddr", i), imemAddr, tbl[i].e_addr);
         chk($sformatf("v%0d instValid", i), {31'd0, instValid}, {31'd0, tbl[i].e_ivld});
         chk($sformatf("v%0d instruction", i), instruction, tbl[i].e_inst);
         chk($sformatf("v%0d misalignFault", i), {31'd0, misalignFault}, {31'd0, tbl[i].e_flt});
         if (tbl[i].e_ivld) begin
            chk($sformatf("v%0d instPC", i), instPC, tbl[i].e_ipc);
            chk($sformatf("v%0d instPCPlus4", i), instPCPlus4, tbl[i].e_ipc + 32'd4);
         end
      end

      // Randomized traffic against the queue model
      reset = 1'b1; redirect = 1'b0; imemValid = 1'b0; decodeReady = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        r_rst;
         logic        r_vld;
         logic        r_rdy;
         logic        r_rdr;
         logic [31:0] r_tgt;
         model_compare(c);
         r_rst = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
         r_vld = ($urandom_range(0, 2) != 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         r_rdr = ($urandom_range(0, 19) == 0);
         r_tgt = $urandom;
         if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0) r_tgt = 32'hFFFF_FFF8;
         reset          = r_rst;
         imemValid      = r_vld;
         decodeReady    = r_rdy;
         redirect       = r_rdr;
         redirectTarget = r_tgt;
         imemData       = mem(imemAddr);
         @(posedge clk);
         model_step(r_rst, r_vld, r_rdy, r_rdr, r_tgt);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the single-cycle core. Sits directly upstream of the control decoder.
- Owns the PC and issues word fetches to instruction memory over a valid/ready-style handshake.
- Presents one registered instruction, plus its PC, to the decoder, with a one-entry prefetch buffer.
- Accepts PC redirects from branch/jal/jalr resolution and flushes in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on instruction when instValid=0 (addi x0,x0,0).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imemReq  output  1  fetch request active.
- imemAddr  output  32  word address of request; equals internal PC.
- imemValid  input  1  imemData holds the word at imemAddr this cycle; only meaningful while imemReq=1.
- imemData  input  32  fetched instruction word.
- decodeReady  input  1  decoder consumes the current instruction at this rising edge.
- instValid  output  1  instruction/instPC are valid.
- instruction  output  32  instruction to the decoder.
- instPC  output  32  PC of instruction.
- instPCPlus4  output  32  instPC+4, combinational, used as the jal/jalr link value.
- redirect  input  1  taken branch / jalEN / jalrEN this cycle.
- redirectTarget  input  32  new PC when redirect=1.
- misalignFault  output  1  sticky: redirect target was not word-aligned.

Behaviour:
- Reset (async, immediate), all registered:
  - pc=RESET_PC, state=IDLE.
  - imemReq=0, instValid=0, instruction=NOP_INST, instPC=0.
  - Prefetch buffer empty, misalignFault=0.
- States:
  - IDLE: request off.
  - WAIT: request on, output empty.
  - HOLD: output valid, request on for next PC.
  - FULL: output valid, buffer valid, request off.
  - HALT: fault.
- IDLE -> WAIT on the first clock edge after reset deasserts.
- imemReq=1 in WAIT and HOLD; imemAddr=pc at all times.
- imemAddr changes only at the edge following an accepted response (imemValid=1 while imemReq=1) or a redirect.
- WAIT:
  - imemValid=1: load output reg {imemData, pc}, pc<=pc+4, go to HOLD.
  - Fetch-to-decoder latency: instValid rises on the edge that samples imemValid.
- HOLD:
  - decodeReady=1 and imemValid=1: output reloads with the new word, pc+=4, stay in HOLD. Throughput is 1 instruction/cycle.
  - decodeReady=1 and imemValid=0: go to WAIT; instValid=0 next cycle.
  - decodeReady=0 and imemValid=1: word goes to the buffer, pc+=4, go to FULL.
  - decodeReady=0 and imemValid=0: hold.
- FULL:
  - decodeReady=1: output reg <= buffer, buffer empty, go to HOLD.
  - imemValid is ignored in FULL, since the request is low.
- decodeReady is ignored while instValid=0.
- Redirect has the highest priority in WAIT, HOLD and FULL:
  - Next cycle: pc=redirectTarget, instValid=0, instruction=NOP_INST, buffer cleared, state=WAIT.
  - Any imemValid in the redirect cycle is discarded.
  - decodeReady in the same cycle counts as consumed; no effect beyond the flush.
- Misaligned redirect (redirectTarget[1:0]!=0):
  - misalignFault=1 (sticky until reset), state=HALT.
  - imemReq=0, instValid=0, pc unchanged.
  - HALT is exited only by reset.
- Redirect in IDLE or HALT is ignored.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC +4 -> 0, with no flag.
- instPCPlus4 wraps the same way.
- Reset asserted mid-fetch: outstanding request abandoned immediately; on release, fetch restarts from RESET_PC.

Test Plan:
- Reset release, memory returns 0x00500093 @0 with 1-cycle latency, decodeReady=1 -> imemAddr 0,4,8...; instValid high from the 2nd cycle; instPC=0, instPCPlus4=4.
- Back-to-back zero-wait memory with decodeReady=1 -> one instruction per cycle, instPC increments by 4 each cycle, no bubbles.
- decodeReady=0 for 3 cycles while words @4 and @8 are returned -> @4 held on output, @8 in buffer, imemReq=0, imemAddr=0xC; decodeReady=1 -> @8 appears next cycle, request resumes at 0xC.
- State FULL, redirect=1 to 0x100 -> next cycle instValid=0, instruction=0x00000013, imemAddr=0x100; buffered word never appears.
- redirectTarget=0x102 -> misalignFault=1, imemReq=0, stays halted until reset; after reset misalignFault=0, imemAddr=RESET_PC.
- redirect to 0xFFFFFFFC, response returned -> instPC=0xFFFFFFFC, instPCPlus4=0, next imemAddr=0.
